// File: rtl/alu_control_sequencer.sv
// Multi-cycle control sequencer for the 10-bit datapath: latches an instruction
// on Exec and walks T0..T3, generating bus, register-file and ALU strobes.
module alu_control_sequencer (
    input  logic       CLKb,
    input  logic       CLRb,
    input  logic       Exec,
    input  logic [9:0] INSTR,
    output logic       IRin,
    output logic [9:0] IR,
    output logic       Extern,
    output logic [3:0] Rout,
    output logic [3:0] Rin,
    output logic       Ain,
    output logic [3:0] FN,
    output logic       Gin,
    output logic       Gout,
    output logic       Done,
    output logic       Busy,
    output logic [1:0] Tstep
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_NEG = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;

    step_t      state, state_nxt;
    logic       armed;
    logic [3:0] op;
    logic [3:0] rx_oh, ry_oh;

    assign op    = IR[9:6];
    assign rx_oh = 4'b0001 << IR[5:4];
    assign ry_oh = 4'b0001 << IR[3:2];
    assign Busy  = (state != T0);
    assign Tstep = state;

    // All state moves on the falling clock edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(negedge CLKb or negedge CLRb) begin
        if (!CLRb) begin
            state <= T0;
            IR    <= '0;
            armed <= 1'b1;
        end else begin
            state <= state_nxt;
            if (IRin) begin
                IR    <= INSTR;
                armed <= 1'b0;
            end else if (!Exec) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // statement can leave a signal unassigned and infer a latch.
        state_nxt = state;
        IRin      = 1'b0;
        Extern    = 1'b0;
        Rout      = 4'b0000;
        Rin       = 4'b0000;
        Ain       = 1'b0;
        FN        = 4'b0000;
        Gin       = 1'b0;
        Gout      = 1'b0;
        Done      = 1'b0;

        unique case (state)
            T0: begin
                // CLRb gate keeps IRin low during reset even with Exec held high.
                IRin = Exec & armed & CLRb;
                if (IRin) state_nxt = T1;
            end
            T1: begin
                case (op)
                    OP_LD: begin
                        Extern    = 1'b1;
                        Rin       = rx_oh;
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_MOV: begin
                        Rout      = ry_oh;
                        Rin       = rx_oh;
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_ADD, OP_SUB, OP_INV, OP_NEG, OP_AND, OP_OR, OP_XOR: begin
                        Rout      = rx_oh;
                        Ain       = 1'b1;
                        state_nxt = T2;
                    end
                    default: begin
                        Done      = 1'b1;
                        state_nxt = T0;
                    end
                endcase
            end
            T2: begin
                FN  = op;
                Gin = 1'b1;
                // Unary ops take their only operand from A; the bus stays idle.
                if (op != OP_INV && op != OP_NEG) Rout = ry_oh;
                state_nxt = T3;
            end
            T3: begin
                FN        = op;
                Gout      = 1'b1;
                Rin       = rx_oh;
                Done      = 1'b1;
                state_nxt = T0;
            end
            default: state_nxt = T0;
        endcase
    end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

- Multi-cycle control unit for the 10-bit datapath.
- Latches an instruction word when the operator issues Exec, then steps through T0–T3.
- Generates the bus, register and ALU strobes for each step: register read/write enables, Extern, and the ALU's Ain/FN/Gin/Gout.
- Sits between the external input switches / register file and the ALU; it is the source of every control signal the ALU consumes.

## Interface

Parameters: none.

- CLKb  in  1  system clock; all state updates on the negative edge
- CLRb  in  1  reset, asynchronous, active-low
- Exec  in  1  level start request from operator
- INSTR  in  10  instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored
- IRin  out  1  instruction-register load strobe (mirrors acceptance)
- IR  out  10  latched instruction
- Extern  out  1  drive external data onto shared bus
- Rout  out  4  one-hot register-to-bus enable (bit n = Rn)
- Rin  out  4  one-hot bus-to-register write enable
- Ain  out  1  ALU A-register load
- FN  out  4  ALU function select
- Gin  out  1  ALU G-register load
- Gout  out  1  ALU G-register drives bus
- Done  out  1  final step of current instruction
- Busy  out  1  state ≠ T0
- Tstep  out  2  current step (0..3)

## Operation

Opcodes:
- 0000 LD
- 0001 MOV
- 0010 ADD
- 0011 SUB
- 0100 INV (unary)
- 0101 NEG (unary)
- 0110 AND
- 0111 OR
- 1000 XOR
- 1001–1111 reserved (NOP)

Internal state:
- 2-bit step register.
- IR register.
- `armed` flag: set when Exec is sampled 0, cleared on acceptance.

Step behaviour (all outputs are combinational from state, IR and Exec; outputs not listed are 0):
- T0 idle: IRin = Exec & armed. On a negedge with IRin=1: IR ← INSTR, `armed` ← 0, go to T1.
- T1:
  - LD: Extern=1, Rin[Rx]=1, Done=1, go to T0.
  - MOV: Rout[Ry]=1, Rin[Rx]=1, Done=1, go to T0.
  - ALU ops: Rout[Rx]=1, Ain=1, go to T2.
  - Reserved: Done=1 only, go to T0.
- T2: FN=IR[9:6], Gin=1.
  - Binary ops: also Rout[Ry]=1.
  - Unary ops (INV, NEG): Rout=0000.
  - Go to T3.
- T3: FN=IR[9:6] held, Gout=1, Rin[Rx]=1, Done=1, go to T0.

Output rules:
- FN is 0000 in T0 and T1.
- Rx==Ry is legal; no special case.
- At most one of Extern, any Rout bit, or Gout is high in any cycle; bus contention is impossible by construction.

## Timing

- Reset (CLRb=0, asynchronous):
  - State T0, IR=0, `armed`=1.
  - All outputs 0, including IRin regardless of Exec.
  - Takes effect immediately, including mid-instruction; the aborted instruction writes nothing further.
- Acceptance: the negedge where Exec=1, `armed`=1, state T0.
- Latency after acceptance:
  - LD, MOV, NOP: Done in the cycle following acceptance; back in T0 after 1 further negedge.
  - ALU ops: T1, T2, T3 each one cycle; Done in the 3rd cycle after acceptance.
- Exec held high through and after Done: no re-acceptance. Exec must be sampled 0 in some cycle (any state) to re-arm.
- Exec toggling while Busy: ignored apart from arming.
- INSTR changes after acceptance: no effect; only IR is decoded.

## Test plan

- LD R3, INSTR=0x030, Exec pulse:
  - Acceptance cycle: IRin=1.
  - Next cycle: Extern=1, Rin=1000, Done=1.
  - Then Busy=0, IR=0x030.
- ADD R1,R2, INSTR=0x098:
  - T1: Rout=0010, Ain=1.
  - T2: Rout=0100, FN=0010, Gin=1.
  - T3: Gout=1, Rin=0010, Done=1.
  - Tstep sequence 0,1,2,3,0.
- INV R0, INSTR=0x100:
  - T2: Rout=0000, FN=0100, Gin=1.
  - T3: Rin=0001, Done=1.
- Reserved 0x3C0: T1 shows Done=1, all other strobes 0, then T0.
- Exec held high 10 cycles with MOV R0,R1 (0x044): exactly one instruction executes. Drop Exec for one cycle and raise it: second execution occurs.
- CLRb pulsed low during T2 of SUB (0x0D8):
  - Outputs 0 immediately, Tstep=0, IR=0.
  - No Gout/Rin occurs afterwards.
  - Next Exec is accepted normally.
